// File: rtl/pipeline_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | pipe_pkg: shared FSM state and forwarding-select encodings for     |
// | pipeline_ctrl.                                                     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // x0 is hard-wired zero, so it never takes a forwarded value.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] rs,
    input logic [4:0] mem_rd,
    input logic       mem_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    if (rs != 5'd0 && mem_we && mem_rd == rs) return FWD_MEM;
    if (rs != 5'd0 && wb_we && wb_rd == rs)   return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
// +--------------------------------------------------------------------+
// | pipeline_ctrl_if: decoder/hazard inputs and pipeline enables,      |
// | flushes and forwarding selects of pipeline_ctrl.                   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface pipeline_ctrl_if;

  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic       id_use_rs1_i;
  logic       id_use_rs2_i;
  logic [4:0] ex_rs1_i;
  logic [4:0] ex_rs2_i;
  logic [4:0] ex_rd_i;
  logic       ex_mem_read_i;
  logic       ex_redirect_i;
  logic [4:0] mem_rd_i;
  logic       mem_reg_write_i;
  logic [4:0] wb_rd_i;
  logic       wb_reg_write_i;
  logic       dmem_req_i;
  logic       dmem_ready_i;
  logic       pc_we_o;
  logic       if_id_we_o;
  logic       id_ex_we_o;
  logic       ex_mem_we_o;
  logic       mem_wb_we_o;
  logic       if_id_flush_o;
  logic       id_ex_flush_o;
  logic [1:0] fwd_a_o;
  logic [1:0] fwd_b_o;
  logic       halted_o;
  logic [1:0] state_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           ex_rs1_i, ex_rs2_i, ex_rd_i, ex_mem_read_i, ex_redirect_i,
           mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i,
           dmem_req_i, dmem_ready_i,
    input  pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o,
           if_id_flush_o, id_ex_flush_o, fwd_a_o, fwd_b_o, halted_o, state_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           ex_rs1_i, ex_rs2_i, ex_rd_i, ex_mem_read_i, ex_redirect_i,
           mem_rd_i, mem_reg_write_i, wb_rd_i, wb_reg_write_i,
           dmem_req_i, dmem_ready_i,
    output pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o, mem_wb_we_o,
           if_id_flush_o, id_ex_flush_o, fwd_a_o, fwd_b_o, halted_o, state_o
  );

endinterface

`default_nettype wire

// File: rtl/fwd_unit.sv
// +--------------------------------------------------------------------+
// | fwd_unit: combinational EX operand forwarding selects, MEM stage   |
// | has priority over WB.                                              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_select(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign fwd_b = fwd_select(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// +--------------------------------------------------------------------+
// | pipeline_ctrl: 5-stage RV32I hazard/sequencing controller with     |
// | memory-wait FSM and timeout halt. Optional counters: PIPE_PERF_CNT_EN|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  pipeline_ctrl_if.slave   bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  state_e            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic              w_luh, w_service;
  logic              w_pc_we, w_if_id_we, w_id_ex_we, w_ex_mem_we, w_mem_wb_we;
  logic              w_if_id_flush, w_id_ex_flush;
  logic [1:0]        w_fwd_a, w_fwd_b;

  fwd_unit u_fwd (
    .ex_rs1        (bus.ex_rs1_i),
    .ex_rs2        (bus.ex_rs2_i),
    .mem_rd        (bus.mem_rd_i),
    .mem_reg_write (bus.mem_reg_write_i),
    .wb_rd         (bus.wb_rd_i),
    .wb_reg_write  (bus.wb_reg_write_i),
    .fwd_a         (w_fwd_a),
    .fwd_b         (w_fwd_b)
  );

  assign w_luh = bus.ex_mem_read_i && (bus.ex_rd_i != 5'd0) &&
                 ((bus.id_use_rs1_i && bus.id_rs1_i == bus.ex_rd_i) ||
                  (bus.id_use_rs2_i && bus.id_rs2_i == bus.ex_rd_i));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_service      = 1'b0;
    w_pc_we        = 1'b0;
    w_if_id_we     = 1'b0;
    w_id_ex_we     = 1'b0;
    w_ex_mem_we    = 1'b0;
    w_mem_wb_we    = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (bus.dmem_req_i && !bus.dmem_ready_i) begin
          w_state_nxt    = ST_WAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
        end else begin
          w_service = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus.dmem_ready_i) begin
          w_service      = 1'b1;
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      ST_HALT: ;
      default: w_state_nxt = ST_RUN;
    endcase

    // Redirect squashes the ID instruction, so it wins over a load-use stall.
    if (w_service) begin
      w_ex_mem_we = 1'b1;
      w_mem_wb_we = 1'b1;
      w_id_ex_we  = 1'b1;
      if (bus.ex_redirect_i) begin
        w_pc_we       = 1'b1;
        w_if_id_we    = 1'b1;
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
      end else if (w_luh) begin
        w_id_ex_flush = 1'b1;
      end else begin
        w_pc_we    = 1'b1;
        w_if_id_we = 1'b1;
      end
    end

    if (!reset_ni) begin
      w_pc_we       = 1'b0;
      w_if_id_we    = 1'b0;
      w_id_ex_we    = 1'b0;
      w_ex_mem_we   = 1'b0;
      w_mem_wb_we   = 1'b0;
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end
  end

  assign bus.pc_we_o       = w_pc_we;
  assign bus.if_id_we_o    = w_if_id_we;
  assign bus.id_ex_we_o    = w_id_ex_we;
  assign bus.ex_mem_we_o   = w_ex_mem_we;
  assign bus.mem_wb_we_o   = w_mem_wb_we;
  assign bus.if_id_flush_o = w_if_id_flush;
  assign bus.id_ex_flush_o = w_id_ex_flush;
  assign bus.fwd_a_o       = reset_ni ? w_fwd_a : FWD_RF;
  assign bus.fwd_b_o       = reset_ni ? w_fwd_b : FWD_RF;
  assign bus.halted_o      = (r_state == ST_HALT);
  assign bus.state_o       = r_state;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_we && r_state != ST_HALT) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_if_id_flush)                  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_pipeline_ctrl: randomized and directed self-checking bench for  |
// | pipeline_ctrl against a cycle-level behavioural model.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_ctrl;

  localparam int MAX_WAIT = 15;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  pipeline_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipeline_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(8), .CNT_W(32)) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .bus      (bus)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc,if_id,id_ex,ex_mem,mem_wb we, if_id flush, id_ex flush, fwd_a, fwd_b, halted, state}
  logic [13:0] obs;
  assign obs = {bus.pc_we_o, bus.if_id_we_o, bus.id_ex_we_o, bus.ex_mem_we_o,
                bus.mem_wb_we_o, bus.if_id_flush_o, bus.id_ex_flush_o,
                bus.fwd_a_o, bus.fwd_b_o, bus.halted_o, bus.state_o};

  // Model state: consecutive cycles the memory access has been stalled.
  int          m_stalls;
  logic        m_halted;
  int unsigned m_stall_cnt;
  int unsigned m_flush_cnt;

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (rs != 0 && bus.mem_reg_write_i && bus.mem_rd_i == rs) return 2'd2;
    if (rs != 0 && bus.wb_reg_write_i && bus.wb_rd_i == rs)   return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic stalled_now();
    return (m_stalls == 0) ? (bus.dmem_req_i && !bus.dmem_ready_i) : !bus.dmem_ready_i;
  endfunction

  function automatic logic [13:0] model_out();
    logic [6:0] ctl;
    logic [3:0] fw;
    logic       luh;
    fw = {fwd_ref(bus.ex_rs1_i), fwd_ref(bus.ex_rs2_i)};
    if (!reset_n)  return {7'b0000011, 4'b0000, 1'b0, 2'b00};
    if (m_halted)  return {7'b0000000, fw, 1'b1, 2'b10};
    luh = bus.ex_mem_read_i && bus.ex_rd_i != 0 &&
          ((bus.id_use_rs1_i && bus.id_rs1_i == bus.ex_rd_i) ||
           (bus.id_use_rs2_i && bus.id_rs2_i == bus.ex_rd_i));
    if (stalled_now())          ctl = 7'b0000000;
    else if (bus.ex_redirect_i) ctl = 7'b1111111;
    else if (luh)               ctl = 7'b0011101;
    else                        ctl = 7'b1111100;
    return {ctl, fw, 1'b0, (m_stalls > 0) ? 2'b01 : 2'b00};
  endfunction

  always @(posedge clk or negedge reset_n) begin : model_upd
    logic [13:0] e;
    if (!reset_n) begin
      m_stalls    <= 0;
      m_halted    <= 1'b0;
      m_stall_cnt <= 0;
      m_flush_cnt <= 0;
    end else begin
      e = model_out();
      if (!e[13] && !m_halted) m_stall_cnt <= m_stall_cnt + 1;
      if (e[8])                m_flush_cnt <= m_flush_cnt + 1;
      if (!m_halted) begin
        if (stalled_now()) begin
          m_stalls <= m_stalls + 1;
          if (m_stalls + 1 > MAX_WAIT) m_halted <= 1'b1;
        end else begin
          m_stalls <= 0;
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.id_rs1_i = 0; bus.id_rs2_i = 0; bus.id_use_rs1_i = 0; bus.id_use_rs2_i = 0;
    bus.ex_rs1_i = 0; bus.ex_rs2_i = 0; bus.ex_rd_i = 0;
    bus.ex_mem_read_i = 0; bus.ex_redirect_i = 0;
    bus.mem_rd_i = 0; bus.mem_reg_write_i = 0; bus.wb_rd_i = 0; bus.wb_reg_write_i = 0;
    bus.dmem_req_i = 0; bus.dmem_ready_i = 0;
  endtask

  task automatic randomize_inputs(input bit with_mem);
    bus.id_rs1_i = 5'($urandom_range(0, 3)); bus.id_rs2_i = 5'($urandom_range(0, 3));
    bus.id_use_rs1_i = 1'($urandom); bus.id_use_rs2_i = 1'($urandom);
    bus.ex_rs1_i = 5'($urandom_range(0, 3)); bus.ex_rs2_i = 5'($urandom_range(0, 3));
    bus.ex_rd_i = 5'($urandom_range(0, 3));
    bus.ex_mem_read_i = 1'($urandom); bus.ex_redirect_i = ($urandom_range(0, 3) == 0);
    bus.mem_rd_i = 5'($urandom_range(0, 3)); bus.mem_reg_write_i = 1'($urandom);
    bus.wb_rd_i = 5'($urandom_range(0, 3)); bus.wb_reg_write_i = 1'($urandom);
    bus.dmem_req_i   = with_mem && ($urandom_range(0, 2) == 0);
    bus.dmem_ready_i = !with_mem || ($urandom_range(0, 3) != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] e;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs(1'b1);
      @(negedge clk);
      e = model_out();
      n_tests++;
      if (obs !== e || obs !== 14'b00000110000000) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %b expected %b", i, obs, e);
      end
      tick();
    end
    clear_inputs();
    reset_n = 1'b1;
    @(negedge clk);
    e = model_out();
    n_tests++;
    if (obs !== e || obs[13:9] !== 5'b11111) begin
      n_fail++;
      $display("FAIL first_run: got %b expected %b", obs, e);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [13:0] e;
    clear_inputs();
    bus.ex_mem_read_i = 1; bus.ex_rd_i = 5; bus.id_rs1_i = 5; bus.id_rs2_i = 7;
    bus.id_use_rs1_i = 1; bus.id_use_rs2_i = 1;
    @(negedge clk);
    e = model_out();
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL load_use_stall: got %b expected %b", obs, e);
    end
    tick();
    bus.ex_mem_read_i = 0; bus.ex_rd_i = 0;
    @(negedge clk);
    e = model_out();
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL load_use_after: got %b expected %b", obs, e);
    end
    tick();
    bus.ex_mem_read_i = 1; bus.ex_rd_i = 0; bus.id_rs1_i = 0;
    @(negedge clk);
    e = model_out();
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL load_use_x0: got %b expected %b", obs, e);
    end
    tick();
  endtask

  task automatic test_forwarding();
    logic [13:0] e;
    for (int i = 0; i < 33; i++) begin
      clear_inputs();
      if (i < 3) begin
        bus.mem_rd_i = (i == 2) ? 5'd0 : 5'd3; bus.wb_rd_i = (i == 2) ? 5'd0 : 5'd3;
        bus.mem_reg_write_i = (i != 1); bus.wb_reg_write_i = 1;
        bus.ex_rs1_i = (i == 2) ? 5'd0 : 5'd3; bus.ex_rs2_i = bus.ex_rs1_i;
      end else begin
        randomize_inputs(1'b0);
        bus.ex_redirect_i = 0; bus.ex_mem_read_i = 0;
      end
      @(negedge clk);
      e = model_out();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL forwarding[%0d]: got %b expected %b", i, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_wait_redirect();
    logic [13:0] e;
    clear_inputs();
    bus.dmem_req_i = 1; bus.ex_redirect_i = 1;
    bus.ex_mem_read_i = 1; bus.ex_rd_i = 2; bus.id_rs1_i = 2; bus.id_use_rs1_i = 1;
    for (int i = 0; i < 6; i++) begin
      bus.dmem_ready_i = (i == 5);
      @(negedge clk);
      e = model_out();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL wait_redirect[%0d]: got %b expected %b", i, obs, e);
      end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    e = model_out();
    n_tests++;
    if (obs !== e || obs[1:0] !== 2'b00) begin
      n_fail++;
      $display("FAIL wait_release_run: got %b expected %b", obs, e);
    end
    tick();
  endtask

  task automatic test_timeout();
    logic [13:0] e;
    clear_inputs();
    bus.dmem_req_i = 1;
    for (int i = 0; i < 20; i++) begin
      bus.dmem_ready_i = (i >= 18);
      @(negedge clk);
      e = model_out();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL timeout[%0d]: got %b expected %b", i, obs, e);
      end
      tick();
    end
    reset_n = 1'b0;
    #1;
    e = model_out();
    n_tests++;
    if (obs !== e || obs[2:0] !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_reset: got %b expected %b", obs, e);
    end
    tick();
    reset_n = 1'b1;
    clear_inputs();
    bus.dmem_req_i = 1;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    clear_inputs();
    @(negedge clk);
    e = model_out();
    n_tests++;
    if (obs !== e || obs[1:0] !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_wait: got %b expected %b", obs, e);
    end
    tick();
  endtask

  task automatic test_random();
    logic [13:0] e;
    for (int i = 0; i < 400; i++) begin
      randomize_inputs(1'b1);
      reset_n = ($urandom_range(0, 99) != 0);
      @(negedge clk);
      e = model_out();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b expected %b", i, obs, e);
      end
      tick();
    end
    reset_n = 1'b1;
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf();
    reset_n = 1'b0;
    clear_inputs();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      if (i == 1 || i == 3) begin
        bus.ex_mem_read_i = 1; bus.ex_rd_i = 4; bus.id_rs2_i = 4; bus.id_use_rs2_i = 1;
      end
      if (i == 4) bus.ex_redirect_i = 1;
      tick();
    end
    @(negedge clk);
    n_tests++;
    if (stall_cnt !== 32'd2 || flush_cnt !== 32'd1 ||
        stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin
      n_fail++;
      $display("FAIL perf_counts: got stall=%0d flush=%0d expected stall=2 flush=1",
               stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_perf_random();
    test_random();
    @(negedge clk);
    n_tests++;
    if (stall_cnt !== m_stall_cnt || flush_cnt !== m_flush_cnt) begin
      n_fail++;
      $display("FAIL perf_random: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               stall_cnt, flush_cnt, m_stall_cnt, m_flush_cnt);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    clear_inputs();
    #1;
    test_reset();
    test_load_use();
    test_forwarding();
    test_wait_redirect();
    test_timeout();
    test_random();
`ifdef PIPE_PERF_CNT_EN
    test_perf();
    test_perf_random();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Consumes the per-stage control fields produced by the instruction decoder (reg_write, mem_read, mem_write, jump/branch) plus register indices.
- Drives pipeline-register write enables, flushes and EX-stage forwarding selects.
- Owns the data-memory wait handshake and a wait-timeout watchdog that halts the core.

Parameters:
- MAX_WAIT, 15: maximum consecutive MEM wait cycles before halt; range 1..255.
- WAIT_W, 8: width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.
- CNT_W, 32: width of the performance counters (only used with PIPE_PERF_CNT_EN).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- id_rs1_i  in  5  ID-stage rs1 index.
- id_rs2_i  in  5  ID-stage rs2 index.
- id_use_rs1_i  in  1  ID instruction reads rs1.
- id_use_rs2_i  in  1  ID instruction reads rs2.
- ex_rs1_i  in  5  EX-stage rs1 index.
- ex_rs2_i  in  5  EX-stage rs2 index.
- ex_rd_i  in  5  EX-stage rd index.
- ex_mem_read_i  in  1  EX-stage instruction is a load.
- ex_redirect_i  in  1  taken branch or jump resolved in EX.
- mem_rd_i  in  5  MEM-stage rd index.
- mem_reg_write_i  in  1  MEM-stage instruction writes rd.
- wb_rd_i  in  5  WB-stage rd index.
- wb_reg_write_i  in  1  WB-stage instruction writes rd.
- dmem_req_i  in  1  MEM stage is performing a load/store.
- dmem_ready_i  in  1  data memory completes the access this cycle.
- pc_we_o  out  1  PC update enable.
- if_id_we_o  out  1  IF/ID register enable.
- id_ex_we_o  out  1  ID/EX register enable.
- ex_mem_we_o  out  1  EX/MEM register enable.
- mem_wb_we_o  out  1  MEM/WB register enable.
- if_id_flush_o  out  1  IF/ID register loads a NOP.
- id_ex_flush_o  out  1  ID/EX register loads a bubble (all control signals 0).
- fwd_a_o  out  2  EX operand A source: 00 regfile, 01 WB, 10 MEM.
- fwd_b_o  out  2  EX operand B source: same encoding as fwd_a_o.
- halted_o  out  1  sticky; memory timeout occurred.
- state_o  out  2  FSM state: 00 RUN, 01 WAIT, 10 HALT.

Behaviour:
- Reset (reset_ni=0, asynchronous):
  - state=RUN, wait counter=0, halted_o=0.
  - All *_we_o=0; both flushes=1; fwd_*_o=00.
  - First active cycle after release is RUN.
- Register x0 never matches any hazard or forwarding comparison.
- Forwarding (combinational, every state):
  - fwd_a_o=10 if mem_reg_write_i & mem_rd_i==ex_rs1_i;
  - else 01 if wb_reg_write_i & wb_rd_i==ex_rs1_i;
  - else 00.
  - fwd_b_o uses ex_rs2_i with the same rule. MEM has priority over WB.
- Load-use hazard (luh): ex_mem_read_i & ex_rd_i!=0 & ((id_use_rs1_i & id_rs1_i==ex_rd_i) | (id_use_rs2_i & id_rs2_i==ex_rd_i)).
- RUN state, outputs are Mealy with priority wait > redirect > luh:
  - dmem_req_i & !dmem_ready_i:
    - All *_we_o=0, flushes=0.
    - Next state WAIT; wait counter loads 1.
  - ex_redirect_i:
    - All we=1; if_id_flush_o=1; id_ex_flush_o=1.
    - Exactly one flush cycle; a coincident luh is ignored because the ID instruction is squashed.
  - luh:
    - pc_we_o=0, if_id_we_o=0, id_ex_flush_o=1; ex_mem/mem_wb we=1.
    - Single bubble; the condition clears next cycle.
  - Otherwise: all we=1, flushes=0.
- WAIT state:
  - All we=0, flushes=0; the whole pipeline is frozen, so EX inputs, including a pending redirect, are held.
  - On dmem_ready_i: same-cycle outputs equal RUN evaluation with the wait term removed, so a held redirect or luh is serviced in the release cycle; next state RUN; counter cleared.
  - If !dmem_ready_i and counter==MAX_WAIT: next state HALT; counter saturates.
  - Otherwise the counter increments.
- HALT state:
  - All we=0, flushes=0, halted_o=1.
  - Terminal until reset; dmem_ready_i is ignored.
- dmem_ready_i arriving in the same cycle as dmem_req_i in RUN is a zero-wait access: no WAIT entry.
- Reset asserted mid-WAIT returns to the reset values immediately, with no pending state kept.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined, adds output ports stall_cnt_o [CNT_W-1:0] and flush_cnt_o [CNT_W-1:0]:
  - stall_cnt_o increments each cycle pc_we_o=0 while not in HALT.
  - flush_cnt_o increments each cycle if_id_flush_o=1 outside reset.
  - Both wrap modulo 2^CNT_W and reset to 0.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding constants ST_RUN/ST_WAIT/ST_HALT;
  - forwarding encodings FWD_RF=00, FWD_WB=01, FWD_MEM=10.
- Sub-module fwd_unit: purely combinational forwarding selects, instanced once. FSM, hazard logic and counters live in pipeline_ctrl.

Test Plan:
- Reset held 3 cycles, then released -> during reset all we=0, flushes=1, state_o=00. In the first RUN cycle with no hazards, all we=1.
- EX lw x5 with ID add x6,x5,x7 (use_rs1=1) -> exactly one cycle of pc_we=0, if_id_we=0, id_ex_flush=1. Next cycle all we=1.
- mem_rd=3, wb_rd=3, both reg_write=1, ex_rs1=3, ex_rs2=3 -> fwd_a=fwd_b=10. Then with mem_reg_write=0 -> 01. With rd=0 on both -> 00.
- dmem_req=1, ready arrives after 4 cycles with ex_redirect_i=1 held -> 4 WAIT cycles with all we=0. In the release cycle both flushes=1, all we=1; state returns to 00.
- dmem_req=1, ready never asserted, MAX_WAIT=15 -> state_o=10 and halted_o=1 after the 16th stalled cycle. Both stay set until reset_ni pulses low.
- With PIPE_PERF_CNT_EN, 2 load-use stalls + 1 redirect -> stall_cnt_o=2, flush_cnt_o=1.
